// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, write-master FSM encoding and
// the check that tells a successful response from an error.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // OKAY and EXOKAY both count as success; only the MSB marks an error.
  function automatic logic resp_ok(input logic [1:0] resp);
    return !resp[1];
  endfunction

endpackage

// File: rtl/axi_lite_write_master_if.sv
// AXI4-Lite write channels (AW, W, B) bundled for the write master and its slave.
interface axi_lite_write_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              WVALID;
  logic              WREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              BVALID;
  logic [1:0]        BRESP;
  logic              BREADY;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    input  AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    output AWREADY, WREADY, BVALID, BRESP
  );

endinterface

// File: rtl/axi_lite_cmd_fifo.sv
// Synchronous command FIFO with wrap-around pointers (extra MSB distinguishes
// full from empty). Ready and empty flags are registered.
module axi_lite_cmd_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         push_ready,
  input  logic         pop,
  output logic [W-1:0] rd_data_c,
  output logic         empty,
  output logic         empty_nxt_c
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = PW + 1;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic             do_push, do_pop, full_nxt;

  // Next pointers and flags; a push when full and a pop when empty are dropped.
  always_comb begin
    do_push     = push & push_ready;
    do_pop      = pop & ~empty;
    wr_ptr_d    = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(do_pop);
    empty_nxt_c = (wr_ptr_d == rd_ptr_d);
    full_nxt    = (wr_ptr_d[PW] != rd_ptr_d[PW]) &&
                  (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      empty      <= 1'b1;
      push_ready <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      empty      <= empty_nxt_c;
      push_ready <= ~full_nxt;
    end
  end

  always_ff @(posedge ACLK) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

  assign rd_data_c = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/axi_lite_write_master.sv
// AXI4-Lite write master: queues commands, issues AW and W concurrently,
// retries error responses up to MAX_RETRY times and reports each retirement.
module axi_lite_write_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_RETRY = 3,
  localparam int unsigned STRB_W   = DATA_W / 8,
  localparam int unsigned RTRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  axi_lite_write_master_if.master axi,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_data,
  input  logic [STRB_W-1:0]    cmd_strb,
  input  logic [2:0]           cmd_prot,
  output logic                 done_valid,
  output logic [1:0]           done_resp,
  output logic [RTRY_W-1:0]    done_retries,
  output logic                 busy
);

  localparam int unsigned CMD_W = ADDR_W + DATA_W + STRB_W + 3;

  state_t              state_q, state_d;
  logic [CMD_W-1:0]    fifo_rd_c;
  logic                fifo_empty, fifo_empty_nxt_c, pop_c;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [RTRY_W-1:0]   retry_q, retry_d;
  logic                awvalid_d, wvalid_d, bready_d;
  logic [ADDR_W-1:0]   awaddr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [STRB_W-1:0]   wstrb_d;
  logic [2:0]          awprot_d;
  logic                done_valid_d, busy_d;
  logic [1:0]          done_resp_d;
  logic [RTRY_W-1:0]   done_retries_d;

  axi_lite_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .push        (cmd_valid),
    .push_data   ({cmd_addr, cmd_data, cmd_strb, cmd_prot}),
    .push_ready  (cmd_ready),
    .pop         (pop_c),
    .rd_data_c   (fifo_rd_c),
    .empty       (fifo_empty),
    .empty_nxt_c (fifo_empty_nxt_c)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d        = state_q;
    pop_c          = 1'b0;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    retry_d        = retry_q;
    awvalid_d      = axi.AWVALID;
    wvalid_d       = axi.WVALID;
    bready_d       = axi.BREADY;
    awaddr_d       = axi.AWADDR;
    wdata_d        = axi.WDATA;
    wstrb_d        = axi.WSTRB;
    awprot_d       = axi.AWPROT;
    done_valid_d   = 1'b0;
    done_resp_d    = done_resp;
    done_retries_d = done_retries;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c = 1'b1;
          {awaddr_d, wdata_d, wstrb_d, awprot_d} = fifo_rd_c;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (axi.AWVALID && axi.AWREADY) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (axi.WVALID && axi.WREADY) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (axi.BVALID) begin
          bready_d = 1'b0;
          if (!resp_ok(axi.BRESP) && (retry_q < RTRY_W'(MAX_RETRY))) begin
            // Re-issue the same registered command.
            retry_d   = retry_q + RTRY_W'(1);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ST_ISSUE;
          end else begin
            done_valid_d   = 1'b1;
            done_resp_d    = axi.BRESP;
            done_retries_d = retry_q;
            retry_d        = '0;
            state_d        = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = !fifo_empty_nxt_c || (state_d != ST_IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      retry_q      <= '0;
      axi.AWVALID  <= 1'b0;
      axi.WVALID   <= 1'b0;
      axi.BREADY   <= 1'b0;
      axi.AWADDR   <= '0;
      axi.WDATA    <= '0;
      axi.WSTRB    <= '0;
      axi.AWPROT   <= '0;
      done_valid   <= 1'b0;
      done_resp    <= '0;
      done_retries <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      retry_q      <= retry_d;
      axi.AWVALID  <= awvalid_d;
      axi.WVALID   <= wvalid_d;
      axi.BREADY   <= bready_d;
      axi.AWADDR   <= awaddr_d;
      axi.WDATA    <= wdata_d;
      axi.WSTRB    <= wstrb_d;
      axi.AWPROT   <= awprot_d;
      done_valid   <= done_valid_d;
      done_resp    <= done_resp_d;
      done_retries <= done_retries_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_write_master.sv
// Self-checking bench for axi_lite_write_master: directed scenarios plus a
// randomized run, compared against a per-command attempt/response model.
module tb_axi_lite_write_master;
  import axi_lite_pkg::*;

  localparam int unsigned AW = 32, DW = 32, SW = DW / 8;
  localparam int unsigned DEPTH = 4, MAX_RETRY = 3, RW = 2;

  logic          ACLK, ARESET;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          done_valid, busy;
  logic [1:0]    done_resp;
  logic [RW-1:0] done_retries;

  axi_lite_write_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_lite_write_master #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .axi(bus),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .done_valid(done_valid), .done_resp(done_resp),
    .done_retries(done_retries), .busy(busy)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Observed and expected traffic: one AW/W entry per attempt, one done per command.
  logic [AW+2:0]   aw_log[$], exp_aw[$];
  logic [DW+SW-1:0] w_log[$], exp_w[$];
  logic [RW+1:0]   done_q[$], exp_done[$];
  logic [1:0]      resp_script[$];

  // Reference model: a command whose slave answers errs errors before success
  // takes min(errs, MAX_RETRY)+1 attempts and retires with the last response.
  function automatic void plan(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [SW-1:0] s, input logic [2:0] p,
                               input int errs, input logic [1:0] ecode,
                               input logic [1:0] okcode);
    int att;
    att = (errs > int'(MAX_RETRY)) ? int'(MAX_RETRY) + 1 : errs + 1;
    for (int i = 0; i < att; i++) begin
      exp_aw.push_back({a, p});
      exp_w.push_back({d, s});
      resp_script.push_back((i < errs) ? ecode : okcode);
    end
    exp_done.push_back({(errs > int'(MAX_RETRY)) ? ecode : okcode, RW'(att - 1)});
  endfunction

  // Slave responder and protocol monitor, acting on falling edges.
  bit   stall, rand_mode;
  int   aw_delay, w_delay, aw_cnt, w_cnt, aw_lim, w_lim;
  bit   aw_fire, w_fire, b_fire, aw_got, w_got, aw_pend, w_pend, prev_done;
  logic [AW+2:0]    aw_last;
  logic [DW+SW-1:0] w_last;

  initial begin
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BRESP = 2'b00;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BRESP = 2'b00;
        aw_fire = 0; w_fire = 0; b_fire = 0; aw_got = 0; w_got = 0;
        aw_pend = 0; w_pend = 0; prev_done = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
        if (aw_fire) begin check("aw_drop", bus.AWVALID, 0); aw_got = 1; end
        if (w_fire)  begin check("w_drop", bus.WVALID, 0);   w_got = 1;  end
        if (b_fire) begin
          check("bready_drop", bus.BREADY, 0);
          bus.BVALID = 1'b0; aw_got = 0; w_got = 0;
        end
        if (aw_pend) check("aw_hold", {bus.AWVALID, bus.AWADDR, bus.AWPROT}, {1'b1, aw_last});
        if (w_pend)  check("w_hold", {bus.WVALID, bus.WDATA, bus.WSTRB}, {1'b1, w_last});
        if (bus.BREADY) check("bready_after_aw_w", aw_got && w_got, 1);

        if (aw_got && w_got && !bus.BVALID) begin
          bus.BVALID = 1'b1;
          if (resp_script.size() > 0) bus.BRESP = resp_script.pop_front();
          else bus.BRESP = RESP_OKAY;
        end
        b_fire = bus.BVALID && bus.BREADY;

        if (!bus.AWVALID) begin
          bus.AWREADY = 1'b0; aw_cnt = 0;
        end else begin
          if (aw_cnt == 0) aw_lim = rand_mode ? int'($urandom_range(0, 3)) : aw_delay;
          if (!stall && aw_cnt >= aw_lim) bus.AWREADY = 1'b1;
          else begin bus.AWREADY = 1'b0; if (!stall) aw_cnt++; end
        end
        aw_fire = bus.AWVALID && bus.AWREADY;
        if (aw_fire) aw_log.push_back({bus.AWADDR, bus.AWPROT});
        aw_pend = bus.AWVALID && !bus.AWREADY;
        aw_last = {bus.AWADDR, bus.AWPROT};

        if (!bus.WVALID) begin
          bus.WREADY = 1'b0; w_cnt = 0;
        end else begin
          if (w_cnt == 0) w_lim = rand_mode ? int'($urandom_range(0, 3)) : w_delay;
          if (!stall && w_cnt >= w_lim) bus.WREADY = 1'b1;
          else begin bus.WREADY = 1'b0; if (!stall) w_cnt++; end
        end
        w_fire = bus.WVALID && bus.WREADY;
        if (w_fire) w_log.push_back({bus.WDATA, bus.WSTRB});
        w_pend = bus.WVALID && !bus.WREADY;
        w_last = {bus.WDATA, bus.WSTRB};

        if (done_valid) begin
          check("done_pulse", prev_done, 0);
          done_q.push_back({done_resp, done_retries});
        end
        prev_done = done_valid;
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input logic [2:0] p);
    int guard = 0;
    cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_prot = p; cmd_valid = 1'b1;
    while (!cmd_ready && guard < 2000) begin @(negedge ACLK); guard++; end
    check("push_accept", guard < 2000, 1);
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n);
    int guard = 0;
    while (done_q.size() < n && guard < 3000) begin @(negedge ACLK); guard++; end
    check({tag, "_done_in_time"}, done_q.size() >= n, 1);
    repeat (3) @(negedge ACLK);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_attempts_aw"}, aw_log.size(), exp_aw.size());
    check({tag, "_attempts_w"}, w_log.size(), exp_w.size());
    check({tag, "_n_done"}, done_q.size(), exp_done.size());
    for (int i = 0; i < aw_log.size() && i < exp_aw.size(); i++)
      check({tag, "_aw_addr_prot"}, aw_log[i], exp_aw[i]);
    for (int i = 0; i < w_log.size() && i < exp_w.size(); i++)
      check({tag, "_w_data_strb"}, w_log[i], exp_w[i]);
    for (int i = 0; i < done_q.size() && i < exp_done.size(); i++)
      check({tag, "_done_resp_retries"}, done_q[i], exp_done[i]);
    check({tag, "_busy_idle"}, busy, 0);
    aw_log.delete(); w_log.delete(); done_q.delete();
    exp_aw.delete(); exp_w.delete(); exp_done.delete(); resp_script.delete();
  endtask

  initial begin
    bit saw_w_first;
    int guard;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    int errs;

    ARESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
    cmd_strb = '0; cmd_prot = '0;
    stall = 0; rand_mode = 0; aw_delay = 0; w_delay = 0;
    repeat (3) @(negedge ACLK);
    check("rst_awvalid", bus.AWVALID, 0);
    check("rst_wvalid", bus.WVALID, 0);
    check("rst_bready", bus.BREADY, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    ARESET = 1'b0;
    @(negedge ACLK);

    // Single write, slave ready at once: VALIDs rise two edges after the push.
    plan(32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0, RESP_SLVERR, RESP_OKAY);
    push(32'h10, 32'hDEADBEEF, 4'hF, 3'b000);
    check("t1_valids_1cyc", {bus.AWVALID, bus.WVALID}, 2'b00);
    check("t1_busy", busy, 1);
    @(negedge ACLK);
    check("t1_valids_2cyc", {bus.AWVALID, bus.WVALID}, 2'b11);
    check("t1_awaddr", bus.AWADDR, 32'h10);
    wait_done("t1", 1);
    compare_all("t1");

    // W handshake three cycles ahead of AW.
    aw_delay = 4; w_delay = 1; saw_w_first = 0;
    plan(32'h44, 32'h1234_5678, 4'h3, 3'b010, 0, RESP_SLVERR, RESP_OKAY);
    push(32'h44, 32'h1234_5678, 4'h3, 3'b010);
    guard = 0;
    while (!bus.BREADY && guard < 40) begin
      if (!bus.WVALID && bus.AWVALID) saw_w_first = 1;
      @(negedge ACLK); guard++;
    end
    check("t2_w_before_aw", saw_w_first, 1);
    wait_done("t2", 1);
    compare_all("t2");
    aw_delay = 0; w_delay = 0;

    // Two SLVERRs then OKAY: three identical attempts.
    plan(32'h80, 32'hCAFE_F00D, 4'hF, 3'b001, 2, RESP_SLVERR, RESP_OKAY);
    push(32'h80, 32'hCAFE_F00D, 4'hF, 3'b001);
    wait_done("t3", 1);
    compare_all("t3");

    // Persistent DECERR: four attempts, retire with DECERR after three retries.
    plan(32'hC0, 32'h0BAD_0BAD, 4'h1, 3'b111, 5, RESP_DECERR, RESP_OKAY);
    push(32'hC0, 32'h0BAD_0BAD, 4'h1, 3'b111);
    wait_done("t4", 1);
    compare_all("t4");

    // Stalled slave: four queued plus one in flight fills the queue.
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      plan(32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 3'b000, 0, RESP_SLVERR, RESP_OKAY);
      push(32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 3'b000);
    end
    check("t5_cmd_ready_full", cmd_ready, 0);
    check("t5_busy", busy, 1);
    cmd_addr = 32'hBAD0; cmd_data = 32'hBAD0; cmd_valid = 1'b1;
    repeat (3) @(negedge ACLK);
    cmd_valid = 1'b0;
    stall = 0;
    wait_done("t5", 5);
    compare_all("t5");

    // Reset while a write is outstanding and more are queued.
    stall = 1;
    for (int i = 0; i < 3; i++) push(32'h2000 + 32'(i * 4), 32'(i), 4'hF, 3'b000);
    check("t6_pre_awvalid", bus.AWVALID, 1);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("t6_awvalid", bus.AWVALID, 0);
    check("t6_wvalid", bus.WVALID, 0);
    check("t6_bready", bus.BREADY, 0);
    check("t6_busy", busy, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    check("t6_done_valid", done_valid, 0);
    @(negedge ACLK);
    ARESET = 1'b0; stall = 0;
    repeat (6) @(negedge ACLK);
    check("t6_busy_after", busy, 0);
    check("t6_no_done", done_q.size(), 0);
    check("t6_no_traffic", aw_log.size(), 0);
    plan(32'h3000, 32'h5555_AAAA, 4'hC, 3'b100, 1, RESP_SLVERR, RESP_EXOKAY);
    push(32'h3000, 32'h5555_AAAA, 4'hC, 3'b100);
    wait_done("t6", 1);
    compare_all("t6");

    // Randomized commands, ready delays and error counts.
    rand_mode = 1;
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rd = $urandom;
      errs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
      plan(ra, rd, SW'($urandom_range(0, 15)), 3'(i), errs,
           $urandom_range(0, 1) ? RESP_SLVERR : RESP_DECERR,
           $urandom_range(0, 1) ? RESP_OKAY : RESP_EXOKAY);
      push(ra, rd, exp_w[exp_w.size() - 1][SW-1:0], 3'(i));
      repeat ($urandom_range(0, 2)) @(negedge ACLK);
    end
    wait_done("rnd", 16);
    compare_all("rnd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
